// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Central round-robin arbiter for the common data bus. Each functional unit
//   holds req high (with a stable tag/value) until it sees its grant. One
//   winner per cycle is chosen combinationally; its tag/value is registered
//   and broadcast to the reservation stations and the ROB the next cycle.
//
// Optional feature macro: CDB_ARBITER_PRIO0_EN
//   Defined   : requester 0 (branch/SEL unit) wins whenever it requests and
//               flush is low; a requester-0 grant does not move the pointer.
//   Undefined : pure round-robin over all NUM_REQ requesters.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active low
//   req          per-FU request, held until granted
//   req_id       per-FU result tag, FU i at [i*ID_W +: ID_W]
//   req_val      per-FU result value, FU i at [i*VAL_W +: VAL_W]
//   grant        one-hot (or zero) combinational grant
//   flush        squashes granting and the pending broadcast
//   cdb_valid    broadcast valid (registered, masked by flush)
//   cdb_id       broadcast tag, zero when cdb_valid is low
//   cdb_val      broadcast value, zero when cdb_valid is low
//   busy         some request is waiting this cycle
//   conflict_cnt saturating count of cycles with two or more requests

module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 4,
    parameter int VAL_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*ID_W-1:0]  req_id,
    input  logic [NUM_REQ*VAL_W-1:0] req_val,
    output logic [NUM_REQ-1:0]       grant,
    input  logic                     flush,
    output logic                     cdb_valid,
    output logic [ID_W-1:0]          cdb_id,
    output logic [VAL_W-1:0]         cdb_val,
    output logic                     busy,
    output logic [15:0]              conflict_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win_idx;
    logic             win_found;
    logic             grant_any;
    logic [NUM_REQ-1:0] grant_c;
    logic [ID_W-1:0]  sel_id;
    logic [VAL_W-1:0] sel_val;
    logic             multi_req;

    logic             valid_q;
    logic [ID_W-1:0]  id_q;
    logic [VAL_W-1:0] val_q;
    logic [15:0]      cnt_q;

    // Wrap-around search starting at ptr; first requester found wins.
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        grant_c   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
`ifdef CDB_ARBITER_PRIO0_EN
        if (req[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
        end
`endif
        // Reset beats flush, flush beats any grant.
        if (rst && !flush && win_found) grant_c[win_idx] = 1'b1;
    end

    assign grant     = grant_c;
    assign grant_any = |grant_c;
    assign busy      = |(req & ~grant_c);

    // x & (x-1) clears the lowest set bit; anything left means >= 2 requests.
    assign multi_req = |(req & (req - 1'b1));

    always_comb begin
        sel_id  = '0;
        sel_val = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_c[i]) begin
                sel_id  = req_id[i*ID_W +: ID_W];
                sel_val = req_val[i*VAL_W +: VAL_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (grant_any) begin
`ifdef CDB_ARBITER_PRIO0_EN
            if (win_idx != '0) begin
                ptr <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
`else
            ptr <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
        end
    end

    // grant_c is already zero under flush, so one condition clears the bus.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            id_q    <= '0;
            val_q   <= '0;
        end else if (grant_any) begin
            valid_q <= 1'b1;
            id_q    <= sel_id;
            val_q   <= sel_val;
        end else begin
            valid_q <= 1'b0;
            id_q    <= '0;
            val_q   <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (multi_req && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    // A flush also hides the result granted last cycle that is sitting in
    // the register right now, so the squashed broadcast is never seen.
    assign cdb_valid    = valid_q & ~flush;
    assign cdb_id       = flush ? '0 : id_q;
    assign cdb_val      = flush ? '0 : val_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int IW = 4;
    localparam int VW = 8;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*IW-1:0] req_id;
    logic [N*VW-1:0] req_val;
    logic [N-1:0]    grant;
    logic            flush;
    logic            cdb_valid;
    logic [IW-1:0]   cdb_id;
    logic [VW-1:0]   cdb_val;
    logic            busy;
    logic [15:0]     conflict_cnt;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    cdb_arbiter #(.NUM_REQ(N), .ID_W(IW), .VAL_W(VW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_id(req_id), .req_val(req_val),
        .grant(grant), .flush(flush), .cdb_valid(cdb_valid), .cdb_id(cdb_id),
        .cdb_val(cdb_val), .busy(busy), .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int          m_ptr;
    logic        m_v;
    logic [IW-1:0] m_id;
    logic [VW-1:0] m_val;
    logic [15:0] m_cnt;

    // Expectations for the current cycle
    int          e_win;
    logic [N-1:0] e_grant;
    logic        e_busy;
    logic        e_valid;
    logic [IW-1:0] e_id;
    logic [VW-1:0] e_val;

    task automatic model_eval();
        e_win = -1;
        if (rst && !flush) begin
`ifdef CDB_ARBITER_PRIO0_EN
            if (req[0]) e_win = 0;
`endif
            for (int k = 0; k < N && e_win < 0; k++) begin
                if (req[(m_ptr + k) % N]) e_win = (m_ptr + k) % N;
            end
        end
        e_grant = '0;
        if (e_win >= 0) e_grant[e_win] = 1'b1;
        e_busy = 1'b0;
        for (int i = 0; i < N; i++) if (req[i] && i != e_win) e_busy = 1'b1;
        e_valid = flush ? 1'b0 : m_v;
        e_id    = flush ? '0 : m_id;
        e_val   = flush ? '0 : m_val;
    endtask

    task automatic model_clock();
        @(posedge clk);
        if (!rst) begin
            m_ptr = 0; m_v = 1'b0; m_id = '0; m_val = '0; m_cnt = '0;
        end else begin
            if ($countones(req) >= 2 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (e_win >= 0) begin
                m_v   = 1'b1;
                m_id  = req_id[e_win*IW +: IW];
                m_val = req_val[e_win*VW +: VW];
`ifdef CDB_ARBITER_PRIO0_EN
                if (e_win != 0) m_ptr = (e_win + 1) % N;
`else
                m_ptr = (e_win + 1) % N;
`endif
            end else begin
                m_v = 1'b0; m_id = '0; m_val = '0;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_fu(input int i, input logic r, input logic [IW-1:0] id, input logic [VW-1:0] v);
        req[i] = r;
        req_id[i*IW +: IW]  = id;
        req_val[i*VW +: VW] = v;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0;
        for (int i = 0; i < N; i++) set_fu(i, 1'b1, IW'(i + 1), VW'(8'h20 + i));
        for (int c = 0; c < 2; c++) begin
            #1 model_eval();
            compared++;
            if ({grant, cdb_valid, conflict_cnt} !== {4'b0000, 1'b0, 16'h0000} ||
                {busy, cdb_id, cdb_val} !== {e_busy, e_id, e_val}) begin
                mismatched++;
                $display("FAIL reset cyc %0d: got grant=%b v=%b cnt=%h busy=%b id=%h val=%h want grant=0000 v=0 cnt=0000 busy=%b id=%h val=%h",
                         cyc, grant, cdb_valid, conflict_cnt, busy, cdb_id, cdb_val, e_busy, e_id, e_val);
            end
            model_clock();
        end
        rst = 1'b1;
        #1 model_eval();
        compared++;
        if (grant !== 4'b0001 || grant !== e_grant) begin
            mismatched++;
            $display("FAIL reset_release_grant cyc %0d: got %b want 0001", cyc, grant);
        end
        model_clock();
        compared++;
        if (cdb_valid !== 1'b1 || cdb_id !== 4'd1 || cdb_val !== 8'h20) begin
            mismatched++;
            $display("FAIL reset_first_bcast cyc %0d: got v=%b id=%h val=%h want v=1 id=1 val=20",
                     cyc, cdb_valid, cdb_id, cdb_val);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] start_cnt;
        start_cnt = conflict_cnt;
        for (int c = 0; c < 8; c++) begin
            #1 model_eval();
            compared++;
            if ({grant, busy, cdb_valid, cdb_id, cdb_val, conflict_cnt} !==
                {e_grant, e_busy, e_valid, e_id, e_val, m_cnt}) begin
                mismatched++;
                $display("FAIL round_robin cyc %0d: got g=%b b=%b v=%b id=%h val=%h cnt=%h want g=%b b=%b v=%b id=%h val=%h cnt=%h",
                         cyc, grant, busy, cdb_valid, cdb_id, cdb_val, conflict_cnt,
                         e_grant, e_busy, e_valid, e_id, e_val, m_cnt);
            end
            model_clock();
        end
        compared++;
        if (conflict_cnt - start_cnt !== 16'd8) begin
            mismatched++;
            $display("FAIL round_robin_conflicts: got delta %0d want 8", conflict_cnt - start_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] pat [3];
        pat[0] = 4'b0100; pat[1] = 4'b0101; pat[2] = 4'b0101;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < N; i++) set_fu(i, 1'b0, IW'(i + 1), VW'(8'h40 + c));
            if (c < 3) req = pat[c];
            #1 model_eval();
            compared++;
            if ({grant, busy, cdb_valid, cdb_id, cdb_val, conflict_cnt} !==
                {e_grant, e_busy, e_valid, e_id, e_val, m_cnt}) begin
                mismatched++;
                $display("FAIL wrap cyc %0d: got g=%b b=%b v=%b id=%h val=%h cnt=%h want g=%b b=%b v=%b id=%h val=%h cnt=%h",
                         cyc, grant, busy, cdb_valid, cdb_id, cdb_val, conflict_cnt,
                         e_grant, e_busy, e_valid, e_id, e_val, m_cnt);
            end
            model_clock();
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 5; c++) begin
            req = '0;
            flush = (c == 1);
            if (c == 0) set_fu(1, 1'b1, 4'd5, 8'hA7);
            if (c == 1 || c == 2) set_fu(1, 1'b1, 4'd6, 8'h3C);
            #1 model_eval();
            compared++;
            if ({grant, busy, cdb_valid, cdb_id, cdb_val, conflict_cnt} !==
                {e_grant, e_busy, e_valid, e_id, e_val, m_cnt}) begin
                mismatched++;
                $display("FAIL flush cyc %0d: got g=%b b=%b v=%b id=%h val=%h cnt=%h want g=%b b=%b v=%b id=%h val=%h cnt=%h",
                         cyc, grant, busy, cdb_valid, cdb_id, cdb_val, conflict_cnt,
                         e_grant, e_busy, e_valid, e_id, e_val, m_cnt);
            end
            model_clock();
        end
        flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] start_cnt;
        start_cnt = conflict_cnt;
        for (int c = 0; c < 6; c++) begin
            req = '0;
            if (c < 4) set_fu(2, 1'b1, 4'd9, VW'(8'h10 + c));
            #1 model_eval();
            compared++;
            if ({grant, busy, cdb_valid, cdb_id, cdb_val, conflict_cnt} !==
                {e_grant, e_busy, e_valid, e_id, e_val, m_cnt} ||
                busy !== 1'b0 || conflict_cnt !== start_cnt) begin
                mismatched++;
                $display("FAIL back_to_back cyc %0d: got g=%b b=%b v=%b id=%h val=%h cnt=%h want g=%b b=0 v=%b id=%h val=%h cnt=%h",
                         cyc, grant, busy, cdb_valid, cdb_id, cdb_val, conflict_cnt,
                         e_grant, e_valid, e_id, e_val, start_cnt);
            end
            model_clock();
        end
    endtask

    task automatic test_random();
        logic [N-1:0] last_grant;
        last_grant = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                // An ungranted request must be held unchanged.
                if (!(req[i] && !last_grant[i]))
                    set_fu(i, 1'($urandom_range(1, 0)), IW'($urandom), VW'($urandom));
            end
            flush = ($urandom_range(9, 0) == 0);
            rst   = ($urandom_range(39, 0) != 0);
            #1 model_eval();
            compared++;
            if ({grant, busy, cdb_valid, cdb_id, cdb_val, conflict_cnt} !==
                {e_grant, e_busy, e_valid, e_id, e_val, m_cnt}) begin
                mismatched++;
                $display("FAIL random cyc %0d: got g=%b b=%b v=%b id=%h val=%h cnt=%h want g=%b b=%b v=%b id=%h val=%h cnt=%h",
                         cyc, grant, busy, cdb_valid, cdb_id, cdb_val, conflict_cnt,
                         e_grant, e_busy, e_valid, e_id, e_val, m_cnt);
            end
            last_grant = e_grant;
            model_clock();
        end
        rst = 1'b1; flush = 1'b0; req = '0;
        #1 model_eval();
        model_clock();
    endtask

    task automatic test_saturate();
        int extra;
        extra = 0;
        for (int c = 0; c < 70000 && extra < 4; c++) begin
            req = '0;
            set_fu(0, 1'b1, IW'(c), VW'(c));
            set_fu(1, 1'b1, IW'(c + 7), VW'(c + 3));
            #1 model_eval();
            compared++;
            if ({grant, busy, cdb_valid, cdb_id, cdb_val, conflict_cnt} !==
                {e_grant, e_busy, e_valid, e_id, e_val, m_cnt}) begin
                mismatched++;
                $display("FAIL saturate cyc %0d: got g=%b b=%b v=%b id=%h val=%h cnt=%h want g=%b b=%b v=%b id=%h val=%h cnt=%h",
                         cyc, grant, busy, cdb_valid, cdb_id, cdb_val, conflict_cnt,
                         e_grant, e_busy, e_valid, e_id, e_val, m_cnt);
            end
            if (m_cnt == 16'hFFFF) extra++;
            model_clock();
        end
        compared++;
        if (conflict_cnt !== 16'hFFFF) begin
            mismatched++;
            $display("FAIL saturate_final: got cnt=%h want ffff", conflict_cnt);
        end
        req = '0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; req = '0; req_id = '0; req_val = '0;
        @(negedge clk);
        #1 model_eval();
        model_clock();
        test_reset();
        test_round_robin();
        test_wrap();
        test_flush();
        test_back_to_back();
        test_random();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
